// File: rtl/piezo_tone_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_sequencer_pkg
// Brief    : Shared cue IDs, FSM states, note half-periods and ROM entry type
//            for the piezo tone sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package piezo_tone_sequencer_pkg;

   localparam int c_half_w = 18;
   localparam int c_dur_w  = 10;

   // Cue IDs; the numeric value is also the arbitration priority
   localparam logic [2:0] c_cue_none    = 3'd0;
   localparam logic [2:0] c_cue_click   = 3'd1;
   localparam logic [2:0] c_cue_correct = 3'd2;
   localparam logic [2:0] c_cue_fail    = 3'd3;
   localparam logic [2:0] c_cue_clear   = 3'd4;
   localparam logic [2:0] c_cue_explode = 3'd5;

   // main_fsm states that trigger the end-of-game jingles
   localparam logic [2:0] c_st_cleared  = 3'd5;
   localparam logic [2:0] c_st_exploded = 3'd6;

   // Half-periods in 50 MHz clock cycles
   localparam logic [c_half_w-1:0] c_half_2khz  = 18'd12500;
   localparam logic [c_half_w-1:0] c_half_c5    = 18'd47801;
   localparam logic [c_half_w-1:0] c_half_e5    = 18'd37936;
   localparam logic [c_half_w-1:0] c_half_g5    = 18'd31888;
   localparam logic [c_half_w-1:0] c_half_c6    = 18'd23878;
   localparam logic [c_half_w-1:0] c_half_e6    = 18'd18954;
   localparam logic [c_half_w-1:0] c_half_400hz = 18'd62500;
   localparam logic [c_half_w-1:0] c_half_200hz = 18'd125000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [c_half_w-1:0] half;
      logic [c_dur_w-1:0]  dur;
      logic                last;
   } note_t;

   function automatic note_t mk_note(input logic [c_half_w-1:0] half,
                                     input logic [c_dur_w-1:0]  dur,
                                     input logic                last);
      note_t n;
      n.half = half;
      n.dur  = dur;
      n.last = last;
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piezo_tone_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_sequencer_if
// Brief    : Game-status inputs and buzzer/status outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface piezo_tone_sequencer_if;
   logic [2:0] current_state;
   logic       key_pulse;
   logic       correct_pulse;
   logic       fail_pulse;
   logic       warn_active;
   logic       warn_tone;
   logic       mute;
   logic       piezo_out;
   logic       busy;
   logic [2:0] cue_id;

   modport master (
      output current_state, key_pulse, correct_pulse, fail_pulse,
             warn_active, warn_tone, mute,
      input  piezo_out, busy, cue_id
   );

   modport slave (
      input  current_state, key_pulse, correct_pulse, fail_pulse,
             warn_active, warn_tone, mute,
      output piezo_out, busy, cue_id
   );
endinterface
`default_nettype wire

// File: rtl/piezo_tone_sequencer_cue_rom.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_sequencer_cue_rom
// Brief    : Combinational note ROM, {cue, index} -> {half, dur, last}.
// Revision : 1.0 - initial release
// ============================================================================
module piezo_tone_sequencer_cue_rom
   import piezo_tone_sequencer_pkg::*;
(
   input  wire logic [2:0] cue_i,
   input  wire logic [1:0] idx_i,
   output note_t           note_o
);

   // Decode the cue/index pair; unused slots are a one-tick terminal rest
   always_comb begin
      note_o = mk_note('0, 10'd1, 1'b1);
      case ({cue_i, idx_i})
         {c_cue_click,   2'd0}: note_o = mk_note(c_half_2khz,  10'd20,   1'b1);
         {c_cue_correct, 2'd0}: note_o = mk_note(c_half_c6,    10'd100,  1'b0);
         {c_cue_correct, 2'd1}: note_o = mk_note(c_half_e6,    10'd100,  1'b1);
         {c_cue_fail,    2'd0}: note_o = mk_note(c_half_400hz, 10'd150,  1'b0);
         {c_cue_fail,    2'd1}: note_o = mk_note(c_half_200hz, 10'd250,  1'b1);
         {c_cue_clear,   2'd0}: note_o = mk_note(c_half_c5,    10'd120,  1'b0);
         {c_cue_clear,   2'd1}: note_o = mk_note(c_half_e5,    10'd120,  1'b0);
         {c_cue_clear,   2'd2}: note_o = mk_note(c_half_g5,    10'd120,  1'b0);
         {c_cue_clear,   2'd3}: note_o = mk_note(c_half_c6,    10'd120,  1'b1);
         {c_cue_explode, 2'd0}: note_o = mk_note(c_half_200hz, 10'd1000, 1'b1);
         default:               note_o = mk_note('0, 10'd1, 1'b1);
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/piezo_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_sequencer
// Brief    : Priority-arbitrated audio cue player driving the piezo buzzer,
//            with event-1 warning pass-through and mute.
// Revision : 1.0 - initial release
// ============================================================================
module piezo_tone_sequencer
   import piezo_tone_sequencer_pkg::*;
#(
   parameter int TICK_DIV   = 50_000,
   parameter int TONE_SHIFT = 0,
   parameter int GAP_TICKS  = 5
) (
   input wire logic              clk,
   input wire logic              rst,
   piezo_tone_sequencer_if.slave snd_if
);

   localparam int          PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [31:0] c_pre_last = 32'(TICK_DIV - 1);
   localparam logic [31:0] c_gap_tks  = 32'(GAP_TICKS);

   state_t              state_q, state_d;
   logic [2:0]          cue_q, cue_d;
   logic [1:0]          idx_q, idx_d;
   logic [c_half_w-1:0] half_q, half_d;
   logic [c_dur_w-1:0]  dur_q, dur_d;
   logic                last_q, last_d;
   logic                rest_q, rest_d;
   logic [c_half_w-1:0] tone_cnt_q, tone_cnt_d;
   logic                tone_q, tone_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [c_dur_w-1:0]  tick_q, tick_d;
   logic [2:0]          prev_state_q;
   logic                piezo_q;

   note_t               w_note;
   logic [c_half_w-1:0] w_half_shift;
   logic [c_half_w-1:0] w_half_eff;
   logic [2:0]          w_req_id;
   logic                w_accept;
   logic                w_pre_wrap;
   logic                w_play_done;
   logic                w_gap_done;

   piezo_tone_sequencer_cue_rom u_rom (
      .cue_i  (cue_q),
      .idx_i  (idx_q),
      .note_o (w_note)
   );

   // Scale the ROM half-period and never let it reach zero (rests are flagged separately)
   assign w_half_shift = w_note.half >> TONE_SHIFT;
   assign w_half_eff   = (w_half_shift == '0) ? {{(c_half_w-1){1'b0}}, 1'b1} : w_half_shift;

   assign w_pre_wrap  = (32'(pre_q) == c_pre_last);
   assign w_play_done = ((32'(tick_q) + 32'd1) >= 32'(dur_q));
   assign w_gap_done  = ((32'(tick_q) + 32'd1) >= c_gap_tks);

   // Pick the highest-priority request this cycle; preempt only strictly lower cues
   always_comb begin
      w_req_id = c_cue_none;
      if (snd_if.key_pulse)     w_req_id = c_cue_click;
      if (snd_if.correct_pulse) w_req_id = c_cue_correct;
      if (snd_if.fail_pulse)    w_req_id = c_cue_fail;
      if ((snd_if.current_state == c_st_cleared) && (prev_state_q != c_st_cleared))
         w_req_id = c_cue_clear;
      if ((snd_if.current_state == c_st_exploded) && (prev_state_q != c_st_exploded))
         w_req_id = c_cue_explode;
      w_accept = (w_req_id > cue_q);
   end

   // Sequencer next-state: note fetch, tone toggling, duration and gap timing
   always_comb begin
      state_d    = state_q;
      cue_d      = cue_q;
      idx_d      = idx_q;
      half_d     = half_q;
      dur_d      = dur_q;
      last_d     = last_q;
      rest_d     = rest_q;
      tone_cnt_d = tone_cnt_q;
      tone_d     = tone_q;
      pre_d      = pre_q;
      tick_d     = tick_q;

      case (state_q)
         ST_IDLE: begin
            tone_d = 1'b0;
         end
         ST_LOAD: begin
            half_d     = w_half_eff;
            dur_d      = w_note.dur;
            last_d     = w_note.last;
            rest_d     = (w_note.half == '0);
            tone_d     = 1'b0;
            tone_cnt_d = '0;
            pre_d      = '0;
            tick_d     = '0;
            state_d    = ST_PLAY;
         end
         ST_PLAY: begin
            if (!rest_q) begin
               if (tone_cnt_q == (half_q - {{(c_half_w-1){1'b0}}, 1'b1})) begin
                  tone_cnt_d = '0;
                  tone_d     = ~tone_q;
               end else begin
                  tone_cnt_d = tone_cnt_q + {{(c_half_w-1){1'b0}}, 1'b1};
               end
            end
            if (w_pre_wrap) begin
               pre_d = '0;
               if (w_play_done) begin
                  tone_d  = 1'b0;
                  tick_d  = '0;
                  state_d = ST_GAP;
               end else begin
                  tick_d = tick_q + 10'd1;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         ST_GAP: begin
            tone_d = 1'b0;
            if (w_pre_wrap) begin
               pre_d = '0;
               if (w_gap_done) begin
                  tick_d = '0;
                  if (last_q) begin
                     cue_d   = c_cue_none;
                     idx_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     idx_d   = idx_q + 2'd1;
                     state_d = ST_LOAD;
                  end
               end else begin
                  tick_d = tick_q + 10'd1;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An accepted request restarts from the first note of the new cue
      if (w_accept) begin
         cue_d      = w_req_id;
         idx_d      = '0;
         tone_d     = 1'b0;
         tone_cnt_d = '0;
         state_d    = ST_LOAD;
      end
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cue_q      <= c_cue_none;
         idx_q      <= '0;
         half_q     <= '0;
         dur_q      <= '0;
         last_q     <= 1'b0;
         rest_q     <= 1'b0;
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
         pre_q      <= '0;
         tick_q     <= '0;
      end else begin
         state_q    <= state_d;
         cue_q      <= cue_d;
         idx_q      <= idx_d;
         half_q     <= half_d;
         dur_q      <= dur_d;
         last_q     <= last_d;
         rest_q     <= rest_d;
         tone_cnt_q <= tone_cnt_d;
         tone_q     <= tone_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
      end
   end

   // Previous main_fsm state for edge detection, and the registered output mux
   // (fed from tone_d so the buzzer pin toggles on the same edge as the tone)
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_state_q <= 3'd0;
         piezo_q      <= 1'b0;
      end else begin
         prev_state_q <= snd_if.current_state;
         if (snd_if.mute)
            piezo_q <= 1'b0;
         else if (snd_if.warn_active)
            piezo_q <= snd_if.warn_tone;
         else
            piezo_q <= tone_d;
      end
   end

   assign snd_if.piezo_out = piezo_q;
   assign snd_if.busy      = (cue_q != c_cue_none);
   assign snd_if.cue_id    = cue_q;

endmodule
`default_nettype wire
